// File: rtl/pipelined_carry_adder_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipelined_carry_adder_if : operand/result handshake bundle for the     |
// |                            pipelined carry adder                       |
// | Rev 1.0 : initial release                                              |
// +------------------------------------------------------------------------+
interface pipelined_carry_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;
`ifdef PIPELINED_CARRY_ADDER_SATURATE_EN
   logic             sat;

   modport master (
      output in_valid, a, b, carry_in, sub, sat, out_ready,
      input  in_ready, out_valid, sum, carry_out, overflow
   );
   modport slave (
      input  in_valid, a, b, carry_in, sub, sat, out_ready,
      output in_ready, out_valid, sum, carry_out, overflow
   );
`else
   modport master (
      output in_valid, a, b, carry_in, sub, out_ready,
      input  in_ready, out_valid, sum, carry_out, overflow
   );
   modport slave (
      input  in_valid, a, b, carry_in, sub, out_ready,
      output in_ready, out_valid, sum, carry_out, overflow
   );
`endif
endinterface
`default_nettype wire

// File: rtl/pipelined_carry_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipelined_carry_adder : WIDTH-bit add/subtract, carry rippling one     |
// |   SLICE per clock; optional clamp via PIPELINED_CARRY_ADDER_SATURATE_EN|
// | Rev 1.0 : initial release                                              |
// +------------------------------------------------------------------------+
module pipelined_carry_adder #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  wire                    clk,
   input  wire                    rst_n,
   pipelined_carry_adder_if.slave io_bus
);
   localparam int STAGES = WIDTH / SLICE;

   // r_d[k] holds sum slices 0..k in place and the still-unadded slices of a above them
   logic             r_vld [STAGES];
   logic             r_c   [STAGES];
   logic [WIDTH-1:0] r_d   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic             r_ovf;

   logic             w_vin   [STAGES];
   logic             w_cin   [STAGES];
   logic [WIDTH-1:0] w_din   [STAGES];
   logic [WIDTH-1:0] w_bin   [STAGES];
   logic [WIDTH-1:0] w_dnext [STAGES];
   logic [SLICE:0]   w_full  [STAGES];
   logic             w_stall;
   logic             w_cmsb;
   logic             w_ovf;
   logic [WIDTH-1:0] w_res;

   function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] d,
                                                input logic [SLICE-1:0] s,
                                                input int               lo);
      logic [WIDTH-1:0] m;
      m            = d;
      m[lo+:SLICE] = s;
      return m;
   endfunction

   assign w_stall         = io_bus.out_valid && !io_bus.out_ready;
   assign io_bus.in_ready = !w_stall;

`ifdef PIPELINED_CARRY_ADDER_SATURATE_EN
   localparam logic [WIDTH-1:0] c_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   logic r_sat    [STAGES];
   logic w_sat_in [STAGES];
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign w_vin[k] = io_bus.in_valid;
         assign w_din[k] = io_bus.a;
         assign w_bin[k] = io_bus.sub ? ~io_bus.b : io_bus.b;
         assign w_cin[k] = io_bus.sub | io_bus.carry_in;
`ifdef PIPELINED_CARRY_ADDER_SATURATE_EN
         assign w_sat_in[k] = io_bus.sat;
`endif
      end else begin : g_body
         assign w_vin[k] = r_vld[k-1];
         assign w_din[k] = r_d[k-1];
         assign w_bin[k] = r_b[k-1];
         assign w_cin[k] = r_c[k-1];
`ifdef PIPELINED_CARRY_ADDER_SATURATE_EN
         assign w_sat_in[k] = r_sat[k-1];
`endif
      end

      assign w_full[k]  = {1'b0, w_din[k][k*SLICE +: SLICE]}
                        + {1'b0, w_bin[k][k*SLICE +: SLICE]}
                        + {{SLICE{1'b0}}, w_cin[k]};
      assign w_dnext[k] = f_merge(w_din[k], w_full[k][SLICE-1:0], k*SLICE);
   end

   // Carry into the MSB recovered from the MSB sum bit and its two operand bits
   assign w_cmsb = w_full[STAGES-1][SLICE-1] ^ w_din[STAGES-1][WIDTH-1]
                 ^ w_bin[STAGES-1][WIDTH-1];
   assign w_ovf  = w_cmsb ^ w_full[STAGES-1][SLICE];

`ifdef PIPELINED_CARRY_ADDER_SATURATE_EN
   // Overflowed result MSB set means the true result was positive
   assign w_res = (w_sat_in[STAGES-1] && w_ovf)
                ? (w_full[STAGES-1][SLICE-1] ? c_SAT_MAX : c_SAT_MIN)
                : w_dnext[STAGES-1];
`else
   assign w_res = w_dnext[STAGES-1];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= 1'b0;
            r_c[k]   <= 1'b0;
            r_d[k]   <= '0;
            r_b[k]   <= '0;
`ifdef PIPELINED_CARRY_ADDER_SATURATE_EN
            r_sat[k] <= 1'b0;
`endif
         end
         r_ovf <= 1'b0;
      end else if (!w_stall) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= w_vin[k];
            r_c[k]   <= w_full[k][SLICE];
            r_d[k]   <= (k == STAGES-1) ? w_res : w_dnext[k];
            r_b[k]   <= w_bin[k];
`ifdef PIPELINED_CARRY_ADDER_SATURATE_EN
            r_sat[k] <= w_sat_in[k];
`endif
         end
         r_ovf <= w_ovf;
      end
   end

   assign io_bus.out_valid = r_vld[STAGES-1];
   assign io_bus.sum       = r_d[STAGES-1];
   assign io_bus.carry_out = r_c[STAGES-1];
   assign io_bus.overflow  = r_ovf;

endmodule
`default_nettype wire
